// File: rtl/byte_mem_seq.sv
// Byte-serial sequencer: turns one multi-byte big-endian load/store into byte accesses on a byte-wide RAM.
// Optional define BYTE_MEM_SEQ_BOUND_CHK_EN adds rsp_err and rejects requests that run past the top address.
module byte_mem_seq #(
    parameter int ADDR_W     = 16,
    parameter int WORD_BYTES = 4,
    parameter int RD_LAT     = 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [3:0]              req_nbytes,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [8*WORD_BYTES-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [8*WORD_BYTES-1:0] rsp_rdata,
    output logic                    busy,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [7:0]              mem_din,
    input  logic [7:0]              mem_dout
`ifdef BYTE_MEM_SEQ_BOUND_CHK_EN
    ,
    output logic                    rsp_err
`endif
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DRAIN, WR, RESP} state_t;

    state_t                  state;
    logic [3:0]              n_reg;
    logic [4:0]              cyc;
    logic [8*WORD_BYTES-1:0] acc;
    logic [8*WORD_BYTES-1:0] wbuf;

    logic [3:0]              eff_n;
    logic                    accept;
    logic [8*WORD_BYTES-1:0] wshift;
    logic [8*WORD_BYTES-1:0] acc_next;
    logic [4:0]              first_cap;
    logic [4:0]              last_cap;
    logic [4:0]              last_idx;

    assign eff_n  = (req_nbytes == 4'd0 || req_nbytes > 4'(WORD_BYTES)) ? 4'(WORD_BYTES) : req_nbytes;
    assign accept = req_valid && req_ready;

    // Store data is left-aligned so the first (most significant) byte always sits at the top.
    assign wshift    = req_wdata << (8 * (WORD_BYTES - int'(eff_n)));
    assign acc_next  = (acc << 8) | (8*WORD_BYTES)'(mem_dout);
    assign first_cap = 5'(RD_LAT);
    assign last_cap  = 5'(n_reg) + 5'(RD_LAT) - 5'd1;
    assign last_idx  = 5'(n_reg) - 5'd1;

`ifdef BYTE_MEM_SEQ_BOUND_CHK_EN
    logic [ADDR_W:0] end_addr;
    logic            out_of_range;

    assign end_addr     = {1'b0, req_addr} + (ADDR_W+1)'(eff_n) - (ADDR_W+1)'(1);
    assign out_of_range = end_addr[ADDR_W];
`endif

    // cyc counts edges since acceptance; read byte i is captured when cyc == i + RD_LAT.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            n_reg     <= '0;
            cyc       <= '0;
            acc       <= '0;
            wbuf      <= '0;
`ifdef BYTE_MEM_SEQ_BOUND_CHK_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef BYTE_MEM_SEQ_BOUND_CHK_EN
            rsp_err   <= 1'b0;
`endif
            if (accept) begin
                n_reg <= eff_n;
                cyc   <= '0;
                acc   <= '0;
`ifdef BYTE_MEM_SEQ_BOUND_CHK_EN
                if (out_of_range) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                end else
`endif
                begin
                    req_ready <= 1'b0;
                    busy      <= 1'b1;
                    mem_addr  <= req_addr;
                    if (req_write) begin
                        state   <= WR;
                        mem_we  <= 1'b1;
                        mem_din <= wshift[8*WORD_BYTES-1 -: 8];
                        wbuf    <= wshift << 8;
                    end else begin
                        state <= RD_ISSUE;
                    end
                end
            end else begin
                case (state)
                    RD_ISSUE, RD_DRAIN: begin
                        cyc <= cyc + 5'd1;
                        if (state == RD_ISSUE) begin
                            if (cyc == last_idx)
                                state <= RD_DRAIN;
                            else
                                mem_addr <= mem_addr + ADDR_W'(1);
                        end
                        if (cyc >= first_cap)
                            acc <= acc_next;
                        if (cyc == last_cap) begin
                            state     <= RESP;
                            rsp_rdata <= acc_next;
                            rsp_valid <= 1'b1;
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                    WR: begin
                        cyc <= cyc + 5'd1;
                        if (cyc == last_idx) begin
                            mem_we    <= 1'b0;
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                            mem_din  <= wbuf[8*WORD_BYTES-1 -: 8];
                            wbuf     <= wbuf << 8;
                        end
                    end
                    RESP:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
